// File: rtl/fpu_fdiv_wb_buffer.sv
// Purpose: one-entry holding buffer that merges fdiv/fsqrt results onto the FP
//          register-file write port shared with the main FPU (main FPU wins).
// Latency: result accepted in cycle N is written in N+1 at the earliest.
// Backpressure: fdiv_yumi_o withheld while the held entry cannot drain;
//          optional starvation guard raises stall_fpu_o to force a drain.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   fdiv_*                     divider result side (v/rd/result/fflags in, yumi out)
//   fpu_wb_*                   main FPU write request (cannot be stalled)
//   wb_*                       merged register-file write port
//   fdiv_wb_o                  current write is an fdiv/fsqrt result
//   fflags_v_o, fflags_o       fdiv exception flags to accumulate this cycle
//   stall_fpu_o                ask upstream to stop issuing main-FPU ops
//
// Build option: define FPU_FDIV_WB_STARVE_GUARD_EN to build the starvation
// counter; otherwise stall_fpu_o is tied low and a held result may wait
// indefinitely behind fpu_wb_v_i.

module fpu_fdiv_wb_buffer #(
    parameter int exp_width_p      = 8,
    parameter int sig_width_p      = 24,
    parameter int reg_addr_width_p = 5,
    parameter int max_stall_p      = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic                                 fdiv_v_i,
    input  logic [reg_addr_width_p-1:0]          fdiv_rd_i,
    input  logic [exp_width_p+sig_width_p:0]     fdiv_result_i,
    input  logic [4:0]                           fdiv_fflags_i,
    output logic                                 fdiv_yumi_o,

    input  logic                                 fpu_wb_v_i,
    input  logic [reg_addr_width_p-1:0]          fpu_wb_rd_i,
    input  logic [exp_width_p+sig_width_p:0]     fpu_wb_data_i,

    output logic                                 wb_v_o,
    output logic [reg_addr_width_p-1:0]          wb_rd_o,
    output logic [exp_width_p+sig_width_p:0]     wb_data_o,
    output logic                                 fdiv_wb_o,
    output logic                                 fflags_v_o,
    output logic [4:0]                           fflags_o,
    output logic                                 stall_fpu_o
);

    localparam int dataWidth = exp_width_p + sig_width_p + 1;

    logic                        buf_v_r;
    logic [reg_addr_width_p-1:0] buf_rd_r;
    logic [dataWidth-1:0]        buf_data_r;
    logic [4:0]                  buf_fflags_r;

    logic drain;
    logic blocked;

    // Outputs are forced low during the reset cycle because reset is
    // synchronous: buf_v_r/stall_r still hold pre-reset values in that cycle.
    assign drain       = ~reset_i & buf_v_r & ~fpu_wb_v_i;
    assign blocked     = buf_v_r & fpu_wb_v_i;
    assign fdiv_yumi_o = ~reset_i & fdiv_v_i & (~buf_v_r | drain);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_v_r <= 1'b0;
        end else if (fdiv_yumi_o) begin
            buf_v_r <= 1'b1;
        end else if (drain) begin
            buf_v_r <= 1'b0;
        end
    end

    // Data registers are qualified by buf_v_r and need no reset.
    always_ff @(posedge clk_i) begin
        if (fdiv_yumi_o) begin
            buf_rd_r     <= fdiv_rd_i;
            buf_data_r   <= fdiv_result_i;
            buf_fflags_r <= fdiv_fflags_i;
        end
    end

    // Write-port mux: main FPU has absolute priority.
    always_comb begin
        wb_v_o    = 1'b0;
        wb_rd_o   = buf_rd_r;
        wb_data_o = buf_data_r;
        fdiv_wb_o = 1'b0;
        if (!reset_i) begin
            if (fpu_wb_v_i) begin
                wb_v_o    = 1'b1;
                wb_rd_o   = fpu_wb_rd_i;
                wb_data_o = fpu_wb_data_i;
            end else begin
                wb_v_o    = buf_v_r;
                fdiv_wb_o = buf_v_r;
            end
        end
    end

    assign fflags_v_o = drain;
    assign fflags_o   = buf_fflags_r;

`ifdef FPU_FDIV_WB_STARVE_GUARD_EN
    localparam int cntWidth = $clog2(max_stall_p + 1);
    localparam logic [cntWidth-1:0] maxCnt = cntWidth'(max_stall_p);

    logic [cntWidth-1:0] stall_cnt_r;
    logic                stall_r;

    // Counts consecutive cycles the held result loses the port. Once it has
    // lost max_stall_p times and is still blocked, request an issue stall so
    // the main FPU pipeline empties and the buffer gets a free slot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_r <= '0;
            stall_r     <= 1'b0;
        end else begin
            if (!buf_v_r || drain) begin
                stall_cnt_r <= '0;
            end else if (blocked && stall_cnt_r != maxCnt) begin
                stall_cnt_r <= stall_cnt_r + 1'b1;
            end

            if (drain) begin
                stall_r <= 1'b0;
            end else if (blocked && stall_cnt_r == maxCnt) begin
                stall_r <= 1'b1;
            end
        end
    end

    assign stall_fpu_o = stall_r & ~reset_i;
`else
    assign stall_fpu_o = 1'b0;
`endif

    a_yumi_needs_valid: assert property (@(posedge clk_i) fdiv_yumi_o |-> fdiv_v_i);
    a_single_source:    assert property (@(posedge clk_i) !(wb_v_o && fdiv_wb_o && fpu_wb_v_i));

endmodule

// File: tb/tb_fpu_fdiv_wb_buffer.sv
// Purpose: self-checking bench for fpu_fdiv_wb_buffer using a result scoreboard.
// Latency: checks fdiv writes land one or more cycles after acceptance.
// Backpressure: models yumi from buffer occupancy and main-FPU priority.

module tb_fpu_fdiv_wb_buffer;

    localparam int AW = 5;
    localparam int DW = 33;
`ifdef FPU_FDIV_WB_STARVE_GUARD_EN
    localparam bit guardOn = 1'b1;
`else
    localparam bit guardOn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          fdiv_v_i = 1'b0;
    logic [AW-1:0] fdiv_rd_i = '0;
    logic [DW-1:0] fdiv_result_i = '0;
    logic [4:0]    fdiv_fflags_i = '0;
    logic          fdiv_yumi_o;
    logic          fpu_wb_v_i = 1'b0;
    logic [AW-1:0] fpu_wb_rd_i = '0;
    logic [DW-1:0] fpu_wb_data_i = '0;
    logic          wb_v_o;
    logic [AW-1:0] wb_rd_o;
    logic [DW-1:0] wb_data_o;
    logic          fdiv_wb_o;
    logic          fflags_v_o;
    logic [4:0]    fflags_o;
    logic          stall_fpu_o;

    fpu_fdiv_wb_buffer #(
        .exp_width_p(8), .sig_width_p(24), .reg_addr_width_p(AW), .max_stall_p(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fdiv_v_i(fdiv_v_i), .fdiv_rd_i(fdiv_rd_i), .fdiv_result_i(fdiv_result_i),
        .fdiv_fflags_i(fdiv_fflags_i), .fdiv_yumi_o(fdiv_yumi_o),
        .fpu_wb_v_i(fpu_wb_v_i), .fpu_wb_rd_i(fpu_wb_rd_i), .fpu_wb_data_i(fpu_wb_data_i),
        .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .fdiv_wb_o(fdiv_wb_o),
        .fflags_v_o(fflags_v_o), .fflags_o(fflags_o), .stall_fpu_o(stall_fpu_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [4:0]    ff;
    } entT;

    entT fdivQ[$];
    int  total = 0;
    int  bad = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit fv, input int frd, input logic [DW-1:0] fres, input int fff,
                         input bit wv, input int wrd, input logic [DW-1:0] wdat);
        fdiv_v_i      = fv;
        fdiv_rd_i     = AW'(frd);
        fdiv_result_i = fres;
        fdiv_fflags_i = 5'(fff);
        fpu_wb_v_i    = wv;
        fpu_wb_rd_i   = AW'(wrd);
        fpu_wb_data_i = wdat;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, '0);
    endtask

    // Scoreboard step: runs once per cycle at the falling edge. The write
    // port is predicted from the queue of accepted results (pop before push,
    // so a result is never written in its own acceptance cycle).
    task automatic sbStep();
        bit  expYumi;
        entT e;
        if (reset_i) begin
            checkVal("rst_yumi", fdiv_yumi_o, 0);
            checkVal("rst_wb_v", wb_v_o, 0);
            checkVal("rst_fdiv_wb", fdiv_wb_o, 0);
            checkVal("rst_fflags_v", fflags_v_o, 0);
            checkVal("rst_stall", stall_fpu_o, 0);
            fdivQ.delete();
        end else begin
            expYumi = fdiv_v_i && (fdivQ.size() == 0 || !fpu_wb_v_i);
            checkVal("yumi", fdiv_yumi_o, expYumi);
            if (fpu_wb_v_i) begin
                checkVal("fpu_wb_v", wb_v_o, 1);
                checkVal("fpu_wb_rd", wb_rd_o, fpu_wb_rd_i);
                checkVal("fpu_wb_data", wb_data_o, fpu_wb_data_i);
                checkVal("fpu_fdiv_wb", fdiv_wb_o, 0);
                checkVal("fpu_fflags_v", fflags_v_o, 0);
            end else if (fdivQ.size() > 0) begin
                e = fdivQ.pop_front();
                checkVal("div_wb_v", wb_v_o, 1);
                checkVal("div_fdiv_wb", fdiv_wb_o, 1);
                checkVal("div_wb_rd", wb_rd_o, e.rd);
                checkVal("div_wb_data", wb_data_o, e.data);
                checkVal("div_fflags_v", fflags_v_o, 1);
                checkVal("div_fflags", fflags_o, e.ff);
            end else begin
                checkVal("idle_wb_v", wb_v_o, 0);
                checkVal("idle_fdiv_wb", fdiv_wb_o, 0);
                checkVal("idle_fflags_v", fflags_v_o, 0);
            end
            if (expYumi) fdivQ.push_back('{fdiv_rd_i, fdiv_result_i, fdiv_fflags_i});
        end
    endtask

    task automatic sample();
        @(negedge clk_i);
        sbStep();
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [DW-1:0] D1 = 33'h0_3FC0_0000;
    localparam logic [DW-1:0] D2 = 33'h1_2345_6789;
    localparam logic [DW-1:0] D3 = 33'h0_0F0F_0F0F;

    initial begin
        // Reset
        idle();
        reset_i = 1'b1;
        sample(); advance();
        sample(); advance();
        reset_i = 1'b0;

        // Idle port: accepted immediately, written next cycle with flags
        drive(1, 5, D1, 5'h01, 0, 0, '0);
        sample();
        checkVal("idle_yumi_same_cycle", fdiv_yumi_o, 1);
        checkVal("no_bypass", wb_v_o, 0);
        advance();
        idle();
        sample();
        checkVal("idle_wr_v", wb_v_o, 1);
        checkVal("idle_wr_rd", wb_rd_o, 5);
        checkVal("idle_wr_fdiv", fdiv_wb_o, 1);
        checkVal("idle_wr_ffv", fflags_v_o, 1);
        checkVal("idle_wr_ff", fflags_o, 5'h01);
        advance();

        // Conflict: held rd=7 loses the port for three cycles
        drive(1, 7, D2, 5'h02, 0, 0, '0);
        sample(); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, D3, 5'h08, 1, 2, D1);
            sample();
            checkVal("conf_rd_fpu", wb_rd_o, 2);
            checkVal("conf_no_yumi", fdiv_yumi_o, 0);
            advance();
        end
        drive(1, 9, D3, 5'h08, 0, 0, '0);
        sample();
        checkVal("conf_rd7", wb_rd_o, 7);
        checkVal("conf_drain_load_yumi", fdiv_yumi_o, 1);
        advance();
        idle();
        sample();
        checkVal("conf_rd9", wb_rd_o, 9);
        advance();

        // Back-to-back at full throughput
        drive(1, 1, D1, 5'h10, 0, 0, '0);
        sample();
        checkVal("b2b_yumi1", fdiv_yumi_o, 1);
        advance();
        drive(1, 2, D2, 5'h04, 0, 0, '0);
        sample();
        checkVal("b2b_yumi2", fdiv_yumi_o, 1);
        checkVal("b2b_wr1", wb_rd_o, 1);
        advance();
        idle();
        sample();
        checkVal("b2b_wr2", wb_rd_o, 2);
        advance();

        // Starvation: buffer held under a continuously busy main FPU
        drive(1, 11, D3, 5'h04, 1, 3, D2);
        sample(); advance();
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, '0, 0, 1, 3, D2);
            sample();
            checkVal($sformatf("starve_stall_k%0d", k), stall_fpu_o, guardOn && k >= 10);
            checkVal("starve_held", fdiv_wb_o, 0);
            advance();
        end
        idle();
        sample();
        checkVal("starve_drain_rd", wb_rd_o, 11);
        checkVal("starve_drain_fdiv", fdiv_wb_o, 1);
        checkVal("starve_stall_at_drain", stall_fpu_o, guardOn);
        advance();
        sample();
        checkVal("starve_stall_cleared", stall_fpu_o, 0);
        advance();

        // Reset while buffer valid (and stall high when guarded)
        drive(1, 13, D1, 5'h01, 1, 4, D3);
        sample(); advance();
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, '0, 0, 1, 4, D3);
            sample(); advance();
        end
        sample();
        checkVal("pre_rst_stall", stall_fpu_o, guardOn);
        reset_i = 1'b1;
        drive(1, 14, D2, 5'h02, 1, 4, D3);
        sample();
        advance();
        reset_i = 1'b0;
        idle();
        sample();
        checkVal("post_rst_wb_v", wb_v_o, 0);
        checkVal("post_rst_stall", stall_fpu_o, 0);
        advance();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 31), DW'({$urandom, $urandom}),
                  $urandom_range(0, 31), ($urandom_range(0, 99) < 45),
                  $urandom_range(0, 31), DW'({$urandom, $urandom}));
            sample(); advance();
        end
        idle();
        for (int n = 0; n < 3; n++) begin
            sample(); advance();
        end
        checkVal("queue_drained", fdivQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
